shift_seq32: RTL and testbench
==============================

Name: shift_seq32

Overview:
Multi-cycle 32-bit shifter for arbitrary shift amounts, built on a registered datapath that advances two bit positions per clock.
- Iterates a shift-by-2 step, then one shift-by-1 step when the amount is odd.
- Supports four operations: SLL, SRL, SRA and ROL.
- Sits downstream of the operand source and upstream of the result consumer, with a start/busy/done handshake.
- Replaces a full barrel shifter where area matters more than latency.

Parameters:
- WIDTH, 32, data width; must be even and at least 4.
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- entrada  in  WIDTH  operand, captured when start is accepted.
- shamt  in  SHW  shift amount, 0 to WIDTH-1, captured when start is accepted.
- mode  in  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- saida  out  WIDTH  result register, held until the next completion.
- busy  out  1  high from the accept edge until the done edge.
- done  out  1  one-cycle pulse; saida is valid from this cycle onward.

Behaviour:
- Reset, sampled on any rising edge including mid-operation:
  - state=IDLE, saida=0, busy=0, done=0.
  - Internal data and count registers cleared.
  - Any in-flight operation is discarded and produces no done pulse.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - done is a registered output.
- IDLE behaviour on each edge:
  - If start=1: data_r<=entrada, cnt<=shamt, mode_r<=mode, state<=RUN.
  - Otherwise nothing changes.
  - done is cleared on every edge where it is not being set.
- RUN behaviour, evaluated per edge in priority order:
  - cnt>=2: data_r<=step2(data_r), cnt<=cnt-2.
  - cnt==1: data_r<=step1(data_r), cnt<=0.
  - cnt==0: saida<=data_r, done<=1, state<=IDLE.
- Step definitions:
  - SLL: zero fill on the right.
  - SRL: zero fill on the left.
  - SRA: fill with data_r[WIDTH-1].
  - ROL: bits shifted out of the MSB wrap into the LSB.
- Latency: with k = ceil(shamt/2) and the accept edge counted as edge 1, done is high after edge k+2.
  - shamt=0 gives done after edge 2.
  - shamt=31 gives done after edge 18.
- start while busy=1 is ignored, with no queuing; entrada, shamt and mode changes during RUN have no effect.
- start in the cycle where done=1 is accepted, because state is already IDLE. This gives back-to-back throughput of k+2 cycles per operation.
- saida changes only on a done edge or on reset; it holds its value across IDLE and RUN.
- No arithmetic overflow flags. Shift-amount range is limited by the SHW width, so no clamping is needed.

Decomposition:
- Package shift_pkg holds:
  - WIDTH default.
  - enum shift_mode_t {SLL=2'b00, SRL=2'b01, SRA=2'b10, ROL=2'b11}.
  - enum state_t {IDLE, RUN}.
- Sub-module shift_step, combinational:
  - Inputs: data, mode, by2 (1 selects shift-by-2, 0 selects shift-by-1).
  - Output: the shifted value.
  - Instantiated once inside shift_seq32 and fed by data_r.
- FSM, counter and output registers live in shift_seq32.

Test Plan:
1. SLL, entrada=32'h0000_0001, shamt=5 → saida=32'h0000_0020; done pulses exactly once, after edge 5; busy is high for edges 1–4 only.
2. SRA, entrada=32'h8000_0000, shamt=31 → saida=32'hFFFF_FFFF after edge 18. Then SRL with the same operand and shamt=4 → saida=32'h0800_0000.
3. ROL, entrada=32'h8000_0001, shamt=1 → saida=32'h0000_0003. Then shamt=0 with entrada=32'hDEAD_BEEF → saida=32'hDEAD_BEEF, done after edge 2.
4. Start SLL with 32'h1, shamt=8. During RUN, pulse start with entrada=32'hFFFF_FFFF and shamt=1 → the second request is ignored; saida=32'h0000_0100 and only one done pulse occurs.
5. Back-to-back: assert start in the done cycle with SRL, 32'hF000_0000, shamt=2 → accepted immediately; saida=32'h3C00_0000 after 3 further edges.
6. Assert reset for 1 cycle in the middle of a shamt=20 operation → saida=0, busy=0, done=0 on the next cycle, and no done pulse ever appears for the aborted operation. A subsequent request completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle shifter.
package shift_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the shifter: moves data by one or two bit
// positions according to the selected operation.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_t      mode,
  input  logic             by2,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (by2) begin
      unique case (mode)
        SLL: result = {data[WIDTH-3:0], 2'b00};
        SRL: result = {2'b00, data[WIDTH-1:2]};
        SRA: result = {{2{data[WIDTH-1]}}, data[WIDTH-1:2]};
        ROL: result = {data[WIDTH-3:0], data[WIDTH-1:WIDTH-2]};
        default: result = data;
      endcase
    end else begin
      unique case (mode)
        SLL: result = {data[WIDTH-2:0], 1'b0};
        SRL: result = {1'b0, data[WIDTH-1:1]};
        SRA: result = {data[WIDTH-1], data[WIDTH-1:1]};
        ROL: result = {data[WIDTH-2:0], data[WIDTH-1]};
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq32.sv
// Multi-cycle shifter: iterates shift-by-2 steps plus one shift-by-1 step for
// odd amounts, with a start/busy/done handshake.
//
// Handshake: start is sampled only while idle (busy=0); the operands are
// captured on that edge and busy rises. done pulses for one cycle when saida
// is updated, and a new start in that same cycle is accepted immediately.
module shift_seq32
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] entrada,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] saida,
  output logic             busy,
  output logic             done
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   data_r, data_next;
  logic [SHW-1:0]     cnt, cnt_next;
  shift_mode_t        mode_r, mode_next;
  logic [WIDTH-1:0]   saida_next;
  logic               done_next;
  logic [WIDTH-1:0]   step_out;
  logic               step_by2;

  assign step_by2 = (cnt >= SHW'(2));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (data_r),
    .mode   (mode_r),
    .by2    (step_by2),
    .result (step_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_r <= '0;
      cnt    <= '0;
      mode_r <= SLL;
      saida  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      data_r <= data_next;
      cnt    <= cnt_next;
      mode_r <= mode_next;
      saida  <= saida_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    data_next  = data_r;
    cnt_next   = cnt;
    mode_next  = mode_r;
    saida_next = saida;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          data_next  = entrada;
          cnt_next   = shamt;
          mode_next  = shift_mode_t'(mode);
          state_next = RUN;
        end
      end
      RUN: begin
        // cnt reaching zero means data_r already holds the final value.
        if (cnt != '0) begin
          data_next = step_out;
          cnt_next  = step_by2 ? cnt - SHW'(2) : '0;
        end else begin
          saida_next = data_r;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_shift_seq32.sv
// Directed bench for shift_seq32: per-scenario tasks with inline checks.
module tb_shift_seq32;
  localparam int W = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] entrada;
  logic [S-1:0] shamt;
  logic [1:0]   mode;
  logic [W-1:0] saida;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  shift_seq32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .entrada (entrada),
    .shamt   (shamt),
    .mode    (mode),
    .saida   (saida),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Called at a negedge: drives a request so the next posedge is edge 1, and
  // returns at the negedge following edge 1 with start released.
  task automatic launch(input logic [W-1:0] d, input logic [S-1:0] s,
                        input logic [1:0] m);
    start = 1'b1; entrada = d; shamt = s; mode = m;
    @(negedge clk);
    start = 1'b0; entrada = $urandom; shamt = S'($urandom_range(0, 31));
    mode = 2'($urandom_range(0, 3));
  endtask

  // Returns at the negedge where done is seen (or budget expires). edges is
  // the posedge index after which done was observed; busy_bad counts negedges
  // before done where busy was low.
  task automatic wait_done(output int edges, output int busy_bad);
    edges = 1;
    busy_bad = 0;
    while (!done && edges < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; entrada = '0; shamt = '0; mode = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if (saida !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: saida=%h busy=%b done=%b want 0/0/0", saida, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sll();
    int edges, bb, pulses;
    launch(32'h0000_0001, 5'd5, 2'b00);
    wait_done(edges, bb);
    checks++;
    if (edges !== 5) begin errors++; $display("FAIL sll_latency: edge=%0d want 5", edges); end
    checks++;
    if (saida !== 32'h0000_0020) begin errors++; $display("FAIL sll_result: saida=%h want 00000020", saida); end
    checks++;
    if (bb !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL sll_busy: low_count=%0d busy_at_done=%b want 0/0", bb, busy);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL sll_single_done: extra=%0d want 0", pulses); end
    checks++;
    if (saida !== 32'h0000_0020) begin errors++; $display("FAIL sll_hold: saida=%h want 00000020", saida); end
  endtask

  task automatic test_sra_srl();
    int edges, bb;
    launch(32'h8000_0000, 5'd31, 2'b10);
    wait_done(edges, bb);
    checks++;
    if (edges !== 18) begin errors++; $display("FAIL sra_latency: edge=%0d want 18", edges); end
    checks++;
    if (saida !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_result: saida=%h want ffffffff", saida); end
    @(negedge clk);
    launch(32'h8000_0000, 5'd4, 2'b01);
    wait_done(edges, bb);
    checks++;
    if (saida !== 32'h0800_0000 || edges !== 4) begin
      errors++; $display("FAIL srl_result: saida=%h edge=%0d want 08000000/4", saida, edges);
    end
    @(negedge clk);
  endtask

  task automatic test_rol_zero();
    int edges, bb;
    launch(32'h8000_0001, 5'd1, 2'b11);
    wait_done(edges, bb);
    checks++;
    if (saida !== 32'h0000_0003 || edges !== 3) begin
      errors++; $display("FAIL rol_result: saida=%h edge=%0d want 00000003/3", saida, edges);
    end
    @(negedge clk);
    launch(32'hDEAD_BEEF, 5'd0, 2'b11);
    wait_done(edges, bb);
    checks++;
    if (saida !== 32'hDEAD_BEEF || edges !== 2) begin
      errors++; $display("FAIL zero_shift: saida=%h edge=%0d want deadbeef/2", saida, edges);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int pulses, first_edge;
    logic [W-1:0] first_val;
    launch(32'h0000_0001, 5'd8, 2'b00);
    start = 1'b1; entrada = 32'hFFFF_FFFF; shamt = 5'd1; mode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; first_edge = 0; first_val = '0;
    for (int e = 3; e <= 24; e++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) begin first_edge = e - 1; first_val = saida; end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL busy_ignore_pulses: count=%0d want 1", pulses); end
    checks++;
    if (first_val !== 32'h0000_0100 || first_edge !== 6) begin
      errors++; $display("FAIL busy_ignore_result: saida=%h edge=%0d want 00000100/6", first_val, first_edge);
    end
  endtask

  task automatic test_back_to_back();
    int edges, bb;
    launch(32'h0000_000F, 5'd2, 2'b00);
    wait_done(edges, bb);
    checks++;
    if (saida !== 32'h0000_003C || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: saida=%h done=%b want 0000003c/1", saida, done);
    end
    launch(32'hF000_0000, 5'd2, 2'b01);
    wait_done(edges, bb);
    checks++;
    if (saida !== 32'h3C00_0000 || edges !== 3) begin
      errors++; $display("FAIL b2b_second: saida=%h edge=%0d want 3c000000/3", saida, edges);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int pulses, edges, bb;
    launch(32'h0000_0001, 5'd20, 2'b00);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (saida !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: saida=%h busy=%b done=%b want 0/0/0", saida, busy, done);
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL mid_reset_abort: activity=%0d want 0", pulses); end
    launch(32'h0000_00FF, 5'd20, 2'b00);
    wait_done(edges, bb);
    checks++;
    if (saida !== 32'h0FF0_0000 || edges !== 12) begin
      errors++; $display("FAIL mid_reset_after: saida=%h edge=%0d want 0ff00000/12", saida, edges);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sll();
    test_sra_srl();
    test_rol_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
